// File: rtl/segway_pwr_seq_if.sv
// ---------------------------------------------------------------------------
// segway_pwr_seq_if
// Bundles the signals between the rider/auth logic, the balance-math datapath
// and the power/soft-start sequencer.
//   vld        : one-cycle strobe, new PID sample available
//   pwr_req    : level, rider present and power requested
//   steer_req  : level, steering authorised
//   too_fast   : over-speed flag from datapath
//   pwr_up     : datapath enable
//   ss_tmr     : soft-start scale, 8-bit unsigned
//   en_steer   : steering enable to datapath
//   fault      : high while in over-speed FAULT
//   state      : debug state encoding (OFF=0 RAMP=1 RUN=2 FAULT=3 RAMP_DN=4)
// Modports: master drives the requests/strobe, slave is the sequencer.
// ---------------------------------------------------------------------------
interface segway_pwr_seq_if;
  logic       vld;
  logic       pwr_req;
  logic       steer_req;
  logic       too_fast;
  logic       pwr_up;
  logic [7:0] ss_tmr;
  logic       en_steer;
  logic       fault;
  logic [2:0] state;

  modport master (
    output vld, pwr_req, steer_req, too_fast,
    input  pwr_up, ss_tmr, en_steer, fault, state
  );

  modport slave (
    input  vld, pwr_req, steer_req, too_fast,
    output pwr_up, ss_tmr, en_steer, fault, state
  );
endinterface

// File: rtl/segway_pwr_seq.sv
// ---------------------------------------------------------------------------
// segway_pwr_seq
// Power/soft-start sequencer. Ramps ss_tmr up on a power request and down on
// its removal, enables steering only once fully ramped, and backs authority
// down to SS_FLOOR while the datapath reports over-speed. Everything except
// the OFF->RAMP step advances only on cycles where bus.vld is high.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : segway_pwr_seq_if.slave (requests in, registered outputs out)
// ---------------------------------------------------------------------------
module segway_pwr_seq #(
  parameter logic [7:0]  SS_STEP  = 8'd1,
  parameter logic [7:0]  SS_FLOOR = 8'h40,
  parameter int unsigned TF_TRIP  = 3,
  parameter int unsigned TF_CLR   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  segway_pwr_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RAMP    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FAULT   = 3'd3,
    ST_RAMP_DN = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 8;

  // Saturating increment for the sample counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, state_s;
  logic [7:0]       ss_r, ss_s;
  logic [CNT_W-1:0] tcnt_r, tcnt_s;
  logic [CNT_W-1:0] ccnt_r, ccnt_s;
  logic             pwr_up_r, en_steer_r, fault_r;

  logic [8:0]       ss_sum_s;
  logic [7:0]       ss_up_s;
  logic [7:0]       ss_dn_zero_s;
  logic [7:0]       ss_dn_floor_s;
  logic [CNT_W-1:0] tf_next_s;
  logic [CNT_W-1:0] clr_next_s;
  logic             trip_s;

  // Next-state, ramp arithmetic and counter update.
  always_comb begin
    state_s = state_r;
    ss_s    = ss_r;
    tcnt_s  = tcnt_r;
    ccnt_s  = ccnt_r;

    // Ramp up at 9 bits so the carry shows an overflow, then clamp to 255.
    ss_sum_s      = {1'b0, ss_r} + {1'b0, SS_STEP};
    ss_up_s       = ss_sum_s[8] ? 8'hFF : ss_sum_s[7:0];
    ss_dn_zero_s  = (ss_r > SS_STEP) ? (ss_r - SS_STEP) : 8'h00;
    // In FAULT only ever move down toward the floor, never up to it.
    if (ss_r > SS_FLOOR) begin
      ss_dn_floor_s = ((ss_r - SS_FLOOR) > SS_STEP) ? (ss_r - SS_STEP) : SS_FLOOR;
    end else begin
      ss_dn_floor_s = ss_r;
    end
    tf_next_s  = bus.too_fast ? sat_inc(tcnt_r) : {CNT_W{1'b0}};
    clr_next_s = bus.too_fast ? {CNT_W{1'b0}} : sat_inc(ccnt_r);
    trip_s     = (tf_next_s >= CNT_W'(TF_TRIP));

    case (state_r)
      ST_OFF: begin
        ss_s = 8'h00;
        if (bus.pwr_req) begin
          state_s = ST_RAMP;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_RAMP: begin
        if (!bus.vld) begin
          state_s = ST_RAMP;
        end else if (!bus.pwr_req) begin
          state_s = ST_RAMP_DN;
        end else begin
          ss_s   = ss_up_s;
          tcnt_s = tf_next_s;
          if (trip_s) begin
            state_s = ST_FAULT;
          end else if (ss_up_s == 8'hFF) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_RAMP;
          end
        end
      end
      ST_RUN: begin
        ss_s = 8'hFF;
        if (!bus.vld) begin
          state_s = ST_RUN;
        end else if (!bus.pwr_req) begin
          state_s = ST_RAMP_DN;
        end else begin
          tcnt_s = tf_next_s;
          if (trip_s) begin
            state_s = ST_FAULT;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_FAULT: begin
        if (!bus.vld) begin
          state_s = ST_FAULT;
        end else if (!bus.pwr_req) begin
          state_s = ST_RAMP_DN;
        end else begin
          ss_s   = ss_dn_floor_s;
          ccnt_s = clr_next_s;
          if (clr_next_s >= CNT_W'(TF_CLR)) begin
            state_s = ST_RAMP;
          end else begin
            state_s = ST_FAULT;
          end
        end
      end
      ST_RAMP_DN: begin
        if (!bus.vld) begin
          state_s = ST_RAMP_DN;
        end else if (bus.pwr_req) begin
          state_s = ST_RAMP;
        end else begin
          ss_s = ss_dn_zero_s;
          if (ss_dn_zero_s == 8'h00) begin
            state_s = ST_OFF;
          end else begin
            state_s = ST_RAMP_DN;
          end
        end
      end
      default: begin
        state_s = ST_OFF;
        ss_s    = 8'h00;
      end
    endcase

    // Both sample counters restart whenever the state changes.
    if (state_s != state_r) begin
      tcnt_s = {CNT_W{1'b0}};
      ccnt_s = {CNT_W{1'b0}};
    end else begin
      tcnt_s = tcnt_s;
      ccnt_s = ccnt_s;
    end
  end

  // State, ramp and counter registers plus output decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_OFF;
      ss_r       <= 8'h00;
      tcnt_r     <= {CNT_W{1'b0}};
      ccnt_r     <= {CNT_W{1'b0}};
      pwr_up_r   <= 1'b0;
      en_steer_r <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      ss_r       <= ss_s;
      tcnt_r     <= tcnt_s;
      ccnt_r     <= ccnt_s;
      pwr_up_r   <= (state_s != ST_OFF);
      en_steer_r <= (state_s == ST_RUN) & bus.steer_req;
      fault_r    <= (state_s == ST_FAULT);
    end
  end

  assign bus.pwr_up   = pwr_up_r;
  assign bus.ss_tmr   = ss_r;
  assign bus.en_steer = en_steer_r;
  assign bus.fault    = fault_r;
  assign bus.state    = state_r;

endmodule

// File: tb/tb_segway_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_segway_pwr_seq
// Directed bench for segway_pwr_seq: a default-step instance (a) and an
// SS_STEP=3 instance (b) share clock, reset and the vld strobe; each is kept
// in OFF with pwr_req low while the other is exercised.
// ---------------------------------------------------------------------------
module tb_segway_pwr_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  segway_pwr_seq_if a_if ();
  segway_pwr_seq_if b_if ();

  segway_pwr_seq dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  segway_pwr_seq #(.SS_STEP(8'd3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // n one-cycle vld strobes, each followed by an idle cycle; ends on a negedge.
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      a_if.vld = 1'b1;
      b_if.vld = 1'b1;
      @(negedge clk);
      a_if.vld = 1'b0;
      b_if.vld = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_if.vld = 1'b0; a_if.pwr_req = 1'b0; a_if.steer_req = 1'b0; a_if.too_fast = 1'b0;
    b_if.vld = 1'b0; b_if.pwr_req = 1'b0; b_if.steer_req = 1'b0; b_if.too_fast = 1'b0;
    tick(2);
    chk("rst_state", a_if.state, 0);
    chk("rst_ss", a_if.ss_tmr, 0);
    chk("rst_pwr_up", a_if.pwr_up, 0);
    chk("rst_en_steer", a_if.en_steer, 0);
    chk("rst_fault", a_if.fault, 0);
    rst_n = 1'b1;
    tick(1);

    // Power-up ramp to RUN
    a_if.pwr_req = 1'b1;
    a_if.steer_req = 1'b1;
    tick(1);
    chk("up_state_ramp", a_if.state, 1);
    chk("up_pwr_up", a_if.pwr_up, 1);
    chk("up_ss0", a_if.ss_tmr, 0);
    pulses(254);
    chk("up_ss254", a_if.ss_tmr, 254);
    chk("up_still_ramp", a_if.state, 1);
    chk("up_no_steer", a_if.en_steer, 0);
    pulses(1);
    chk("up_ss255", a_if.ss_tmr, 255);
    chk("up_run", a_if.state, 2);
    chk("up_steer", a_if.en_steer, 1);
    pulses(45);
    chk("run_hold_ss", a_if.ss_tmr, 255);
    chk("run_hold_state", a_if.state, 2);
    a_if.steer_req = 1'b0;
    tick(1);
    chk("steer_drop", a_if.en_steer, 0);
    a_if.steer_req = 1'b1;
    tick(1);
    chk("steer_back", a_if.en_steer, 1);

    // Over-speed: 2-sample burst does not trip, 3 consecutive do
    a_if.too_fast = 1'b1;
    pulses(2);
    a_if.too_fast = 1'b0;
    pulses(1);
    chk("burst2_no_fault", a_if.fault, 0);
    a_if.too_fast = 1'b1;
    pulses(2);
    chk("tf2_still_run", a_if.state, 2);
    pulses(1);
    chk("trip_state", a_if.state, 3);
    chk("trip_fault", a_if.fault, 1);
    chk("trip_no_steer", a_if.en_steer, 0);
    chk("trip_ss", a_if.ss_tmr, 255);
    pulses(190);
    chk("fault_ss41", a_if.ss_tmr, 8'h41);
    pulses(1);
    chk("fault_ss40", a_if.ss_tmr, 8'h40);
    pulses(3);
    chk("fault_floor_hold", a_if.ss_tmr, 8'h40);

    // Fault clear needs 16 consecutive clean samples
    a_if.too_fast = 1'b0;
    pulses(15);
    chk("clr15_fault", a_if.state, 3);
    a_if.too_fast = 1'b1;
    pulses(1);
    a_if.too_fast = 1'b0;
    pulses(15);
    chk("clr_restart_fault", a_if.state, 3);
    chk("clr_ss_floor", a_if.ss_tmr, 8'h40);
    pulses(1);
    chk("clr_to_ramp", a_if.state, 1);
    chk("clr_fault_low", a_if.fault, 0);
    chk("clr_ss_from_floor", a_if.ss_tmr, 8'h40);
    pulses(190);
    chk("reramp_ss254", a_if.ss_tmr, 254);
    chk("reramp_state", a_if.state, 1);
    pulses(1);
    chk("reramp_run", a_if.state, 2);
    chk("reramp_ss255", a_if.ss_tmr, 255);

    // Power removal: ramp down to OFF
    a_if.pwr_req = 1'b0;
    pulses(1);
    chk("dn_state", a_if.state, 4);
    chk("dn_no_steer", a_if.en_steer, 0);
    chk("dn_pwr_up", a_if.pwr_up, 1);
    chk("dn_ss255", a_if.ss_tmr, 255);
    pulses(254);
    chk("dn_ss1", a_if.ss_tmr, 1);
    chk("dn_still", a_if.state, 4);
    pulses(1);
    chk("dn_ss0", a_if.ss_tmr, 0);
    chk("dn_off", a_if.state, 0);
    chk("dn_pwr_off", a_if.pwr_up, 0);
    pulses(4);
    chk("off_vld_state", a_if.state, 0);
    chk("off_vld_ss", a_if.ss_tmr, 0);

    // RAMP_DN -> RAMP resumes without discontinuity
    a_if.pwr_req = 1'b1;
    tick(1);
    pulses(128);
    chk("mid_ss80", a_if.ss_tmr, 8'h80);
    a_if.pwr_req = 1'b0;
    pulses(1);
    chk("mid_dn_state", a_if.state, 4);
    a_if.pwr_req = 1'b1;
    pulses(1);
    chk("resume_state", a_if.state, 1);
    chk("resume_ss80", a_if.ss_tmr, 8'h80);
    pulses(1);
    chk("resume_ss81", a_if.ss_tmr, 8'h81);

    // Asynchronous reset mid-RAMP, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", a_if.state, 0);
    chk("arst_ss", a_if.ss_tmr, 0);
    chk("arst_pwr_up", a_if.pwr_up, 0);
    chk("arst_en_steer", a_if.en_steer, 0);
    chk("arst_fault", a_if.fault, 0);
    a_if.pwr_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Boundary build with SS_STEP=3 (b was idling in OFF through all vld above)
    chk("b_idle_state", b_if.state, 0);
    chk("b_idle_ss", b_if.ss_tmr, 0);
    b_if.pwr_req = 1'b1;
    tick(1);
    pulses(84);
    chk("b_ss252", b_if.ss_tmr, 252);
    chk("b_ramp", b_if.state, 1);
    pulses(1);
    chk("b_clamp255", b_if.ss_tmr, 255);
    chk("b_run", b_if.state, 2);
    b_if.too_fast = 1'b1;
    pulses(3);
    chk("b_fault", b_if.state, 3);
    pulses(63);
    chk("b_ss66", b_if.ss_tmr, 66);
    pulses(1);
    chk("b_floor_clamp", b_if.ss_tmr, 8'h40);
    b_if.too_fast = 1'b0;
    b_if.pwr_req = 1'b0;
    pulses(1);
    chk("b_dn_state", b_if.state, 4);
    pulses(21);
    chk("b_ss1", b_if.ss_tmr, 1);
    pulses(1);
    chk("b_zero_clamp", b_if.ss_tmr, 0);
    chk("b_off", b_if.state, 0);
    chk("a_stayed_off", a_if.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/segway_pwr_seq.md
Name: segway_pwr_seq

Overview:
- Power/soft-start sequencer that drives the balance-math datapath's `pwr_up`, `ss_tmr` and `en_steer` inputs.
- Ramps motor authority up on power request and down on power removal.
- Gates steering until the ramp completes.
- Handles over-speed (`too_fast`) by backing authority down to a floor and re-ramping once speed recovers.
- Sits between the rider/auth logic and the math datapath. Advances once per PID sample strobe (`vld`).

Parameters:
- SS_STEP, 8'd1, `ss_tmr` increment/decrement per `vld` pulse while ramping.
- SS_FLOOR, 8'h40, `ss_tmr` level held during over-speed fault.
- TF_TRIP, 3, consecutive `vld` samples with `too_fast`=1 needed to enter FAULT.
- TF_CLR, 16, consecutive `vld` samples with `too_fast`=0 needed to leave FAULT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- vld  in  1  one-cycle strobe, new PID sample available; all ramp/count activity advances only on cycles with vld=1
- pwr_req  in  1  level, rider present and power requested
- steer_req  in  1  level, steering authorised by auth logic
- too_fast  in  1  over-speed flag from datapath
- pwr_up  out  1  datapath enable
- ss_tmr  out  8  soft-start scale, unsigned, 0..255
- en_steer  out  1  steering enable to datapath
- fault  out  1  high while in FAULT
- state  out  3  encoded state for debug: OFF=0, RAMP=1, RUN=2, FAULT=3, RAMP_DN=4

Behaviour:
- All outputs are registered.
- Reset values: state=OFF, ss_tmr=0, pwr_up=0, en_steer=0, fault=0, trip counter=0, clear counter=0.
- Reset mid-operation returns to these values immediately (async).
- State and `ss_tmr` update on the same rising edge on which `vld`=1 is sampled, except OFF->RAMP, which needs no `vld`.
- Output decode, registered alongside state:
  - pwr_up = (state != OFF)
  - en_steer = (state == RUN) & steer_req
  - fault = (state == FAULT)
- Arithmetic: ramp up is ss_tmr = min(ss_tmr + SS_STEP, 255), computed at 9 bits and clamped. Ramp down clamps at its target (0 or SS_FLOOR) and never wraps.
- Over-speed trip counter:
  - In RAMP/RUN, on vld: if too_fast then tcnt++ (saturating), else tcnt=0.
  - Counter cleared on any state change.
- Transition priority:
  - pwr_req=0 wins over all other conditions.
  - Trip wins over ramp completion.
- OFF: ss_tmr=0. pwr_req=1 -> RAMP on next edge.
- RAMP:
  - On vld, ss_tmr ramps up.
  - ss_tmr reaching 255 (post-update) -> RUN.
  - tcnt reaching TF_TRIP -> FAULT.
  - pwr_req=0 -> RAMP_DN.
- RUN:
  - ss_tmr held at 255.
  - tcnt reaching TF_TRIP -> FAULT.
  - pwr_req=0 -> RAMP_DN.
- FAULT:
  - On vld: if ss_tmr > SS_FLOOR, decrement by SS_STEP clamped at SS_FLOOR; else hold (never raised).
  - Clear counter: on vld, too_fast=0 -> ccnt++; too_fast=1 -> ccnt=0.
  - ccnt reaching TF_CLR -> RAMP, ramping from current ss_tmr.
  - pwr_req=0 -> RAMP_DN.
- RAMP_DN:
  - On vld, ss_tmr decrements by SS_STEP clamped at 0.
  - ss_tmr==0 (post-update) -> OFF.
  - pwr_req=1 -> RAMP, continuing from current ss_tmr with no discontinuity.
- `too_fast` is ignored in OFF and RAMP_DN.
- `steer_req` changes take effect the cycle after being sampled, and only in RUN.
- Simultaneous events on one vld:
  - Trip and pwr_req drop together -> RAMP_DN.
  - Ramp reaching 255 and trip together -> FAULT.
- `vld` pulses while in OFF have no effect.

Test Plan:
- Reset, pwr_req=1, 300 vld pulses, too_fast=0, steer_req=1 -> pwr_up=1 one edge after pwr_req; ss_tmr counts 0..255 over 255 vld; state=RUN; en_steer=0 during RAMP and 1 from RUN entry.
- In RUN, pwr_req=0 for 260 vld -> en_steer=0 immediately; ss_tmr 255 down to 0 over 255 vld; then state=OFF, pwr_up=0.
- In RUN, too_fast=1 for 2 vld then 0, then 1 for 3 vld -> no fault after the first burst; FAULT after the 3rd consecutive; ss_tmr decrements to 8'h40 and holds; en_steer=0; fault=1.
- From FAULT, too_fast=0 for 15 vld, 1 for 1, then 0 for 16 -> stays FAULT until the 16th clean sample; then RAMP from 8'h40, reaching RUN after 191 more vld.
- RAMP_DN at ss_tmr=8'h80, re-assert pwr_req -> RAMP, ss_tmr resumes 8'h80 -> 8'h81 on next vld; separately assert rst_n=0 mid-RAMP -> all outputs 0 asynchronously.
- Boundary: SS_STEP=8'd3 build, ramp from 252 -> ss_tmr=255 (no wrap) and RUN; RAMP_DN from 2 -> 0 and OFF.
